// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline register with ready/valid handshake and a 2-entry skid buffer.
// Optional stall counter enabled by defining MEMWB_PERF_CNT_EN.
module memwb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
`ifdef MEMWB_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic [ADDR_W-1:0] branch_addr_in,
  input  logic              pc_src_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_AW-1:0] rd_addr,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              pc_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic [DATA_W-1:0] wb_data
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("memwb_skid_reg: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL2} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_out;
    logic [REG_AW-1:0] rd_addr;
    logic [ADDR_W-1:0] branch_addr;
    logic              pc_src;
    logic              mem_to_reg;
    logic              reg_write;
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   accept;
  logic   drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  assign in_entry = '{mem_data:    mem_data_in,
                      alu_out:     alu_out_in,
                      rd_addr:     rd_addr_in,
                      branch_addr: branch_addr_in,
                      pc_src:      pc_src_in,
                      mem_to_reg:  mem_to_reg_in,
                      reg_write:   reg_write_in};

  // out_valid/in_ready are registered alongside state so neither depends
  // combinationally on out_ready; control bits are cleared on every path to EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state             <= EMPTY;
      out_valid         <= 1'b0;
      in_ready          <= 1'b1;
      main_q.pc_src     <= 1'b0;
      main_q.mem_to_reg <= 1'b0;
      main_q.reg_write  <= 1'b0;
      skid_q.pc_src     <= 1'b0;
      skid_q.mem_to_reg <= 1'b0;
      skid_q.reg_write  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= in_entry;
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q   <= in_entry;
            state    <= FULL2;
            in_ready <= 1'b0;
          end else if (drain) begin
            state             <= EMPTY;
            out_valid         <= 1'b0;
            main_q.pc_src     <= 1'b0;
            main_q.mem_to_reg <= 1'b0;
            main_q.reg_write  <= 1'b0;
          end
        end
        FULL2: begin
          if (drain) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_data    = main_q.mem_data;
  assign alu_out     = main_q.alu_out;
  assign rd_addr     = main_q.rd_addr;
  assign branch_addr = main_q.branch_addr;
  assign pc_src      = main_q.pc_src;
  assign mem_to_reg  = main_q.mem_to_reg;
  assign reg_write   = main_q.reg_write;
  assign wb_data     = main_q.mem_to_reg ? main_q.mem_data : main_q.alu_out;

`ifdef MEMWB_PERF_CNT_EN
  // Saturating count of cycles the writeback stage stalls a valid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Directed self-checking bench for memwb_skid_reg.
// With MEMWB_PERF_CNT_EN defined, the DUT is built with CNT_W=4 and the stall counter is checked.
module tb_memwb_skid_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] alu_out_in;
  logic [REG_AW-1:0] rd_addr_in;
  logic [ADDR_W-1:0] branch_addr_in;
  logic              pc_src_in;
  logic              mem_to_reg_in;
  logic              reg_write_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] alu_out;
  logic [REG_AW-1:0] rd_addr;
  logic [ADDR_W-1:0] branch_addr;
  logic              pc_src;
  logic              mem_to_reg;
  logic              reg_write;
  logic [DATA_W-1:0] wb_data;
`ifdef MEMWB_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memwb_skid_reg #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
`ifdef MEMWB_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_data_in(mem_data_in), .alu_out_in(alu_out_in), .rd_addr_in(rd_addr_in),
    .branch_addr_in(branch_addr_in), .pc_src_in(pc_src_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_data(mem_data), .alu_out(alu_out), .rd_addr(rd_addr),
    .branch_addr(branch_addr), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .wb_data(wb_data)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one MEM-stage entry, then advance one clock and settle 1 time unit past the edge.
  task automatic applyStimulus(input logic valid, input logic [REG_AW-1:0] rd,
                               input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                               input logic m2r, input logic rw, input logic pcs);
    in_valid       = valid;
    rd_addr_in     = rd;
    alu_out_in     = alu;
    mem_data_in    = mem;
    mem_to_reg_in  = m2r;
    reg_write_in   = rw;
    pc_src_in      = pcs;
    branch_addr_in = {{(ADDR_W-DATA_W){1'b0}}, alu} + 32'h100;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; rd_addr_in = '0; alu_out_in = '0; mem_data_in = '0;
    mem_to_reg_in = 1'b0; reg_write_in = 1'b0; pc_src_in = 1'b0; branch_addr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset_reg_write", 64'(reg_write), 64'd0);
    checkOutput("reset_wb_data",   64'(wb_data),   64'd0);
    rst = 1'b0;

    // Streaming with writeback always ready
    out_ready = 1'b1;
    applyStimulus(1'b1, 5'd1, 32'h11, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("stream_alu_0",   64'(alu_out),   64'h11);
    checkOutput("stream_valid_0", 64'(out_valid), 64'd1);
    checkOutput("stream_ready_0", 64'(in_ready),  64'd1);
    applyStimulus(1'b1, 5'd2, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("stream_alu_1",   64'(alu_out),  64'h22);
    checkOutput("stream_ready_1", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 5'd3, 32'h33, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("stream_alu_2",   64'(alu_out),  64'h33);
    checkOutput("stream_rd_2",    64'(rd_addr),  64'd3);
    checkOutput("stream_ready_2", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_empty_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_empty_rw",    64'(reg_write), 64'd0);

    // Writeback data mux
    applyStimulus(1'b1, 5'd9, 32'h1234, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    checkOutput("wb_mux_mem", 64'(wb_data), 64'hDEADBEEF);
    applyStimulus(1'b1, 5'd9, 32'h1234, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    checkOutput("wb_mux_alu", 64'(wb_data), 64'h1234);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("wb_mux_empty", 64'(out_valid), 64'd0);

    // Back-pressure into the skid entry, then ordered release
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'hA, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_one_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 5'd7, 32'hB, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_full_ready", 64'(in_ready),  64'd0);
    checkOutput("bp_full_rd",    64'(rd_addr),   64'd3);
    checkOutput("bp_full_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, 5'd9, 32'hC, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_hold_rd",    64'(rd_addr),  64'd3);
    checkOutput("bp_hold_alu",   64'(alu_out),  64'hA);
    out_ready = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_rel_rd",    64'(rd_addr),   64'd7);
    checkOutput("bp_rel_alu",   64'(alu_out),   64'hB);
    checkOutput("bp_rel_ready", 64'(in_ready),  64'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_rel_empty", 64'(out_valid), 64'd0);

    // Flush from FULL2 discards both held entries and the incoming one
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd4, 32'h44, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd5, 32'h55, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("fl_pre_rw",    64'(reg_write), 64'd1);
    checkOutput("fl_pre_pcsrc", 64'(pc_src),    64'd1);
    flush = 1'b1;
    applyStimulus(1'b1, 5'd6, 32'h66, 32'h0, 1'b0, 1'b1, 1'b1);
    flush = 1'b0;
    checkOutput("fl_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_rw",    64'(reg_write), 64'd0);
    checkOutput("fl_pcsrc", 64'(pc_src),    64'd0);
    checkOutput("fl_ready", 64'(in_ready),  64'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset with FULL2 held, checked before any clock edge
    applyStimulus(1'b1, 5'd10, 32'h77, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd11, 32'h88, 32'h12345678, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    checkOutput("ar_pre_ready", 64'(in_ready), 64'd0);
    checkOutput("ar_pre_wb",    64'(wb_data),  64'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 64'(out_valid), 64'd0);
    checkOutput("ar_rw",    64'(reg_write), 64'd0);
    checkOutput("ar_ready", 64'(in_ready),  64'd1);
    checkOutput("ar_wb",    64'(wb_data),   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef MEMWB_PERF_CNT_EN
    checkOutput("perf_reset", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd12, 32'h99, 32'h0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("perf_sat", 64'(stall_cnt), 64'd15);
    flush = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    checkOutput("perf_flush_keep", 64'(stall_cnt), 64'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memwb_skid_reg.md
Name: memwb_skid_reg

Overview:
- Parametrised MEM/WB pipeline register with a ready/valid handshake and a 2-entry skid buffer.
- Captures MEM-stage results (load data, ALU result, destination register, branch target, control bits) and presents them to writeback.
- Adds back-pressure, synchronous flush and a pre-muxed writeback data output.
- Sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 32, width of load data, ALU result and wb_data
REG_AW, 5, register-file address width
ADDR_W, 32, branch-target address width
CNT_W, 16, stall counter width (used only with the optional feature)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  MEM stage presents an entry
in_ready  output  1  register can accept an entry this cycle
mem_data_in  input  DATA_W  data-memory read value
alu_out_in  input  DATA_W  ALU result
rd_addr_in  input  REG_AW  destination register
branch_addr_in  input  ADDR_W  branch target
pc_src_in  input  1  branch taken
mem_to_reg_in  input  1  select load data for writeback
reg_write_in  input  1  register write enable
out_valid  output  1  entry present at writeback
out_ready  input  1  writeback consumes the entry this cycle
mem_data  output  DATA_W  held load data
alu_out  output  DATA_W  held ALU result
rd_addr  output  REG_AW  held destination
branch_addr  output  ADDR_W  held branch target
pc_src  output  1  held branch-taken, 0 when out_valid=0
mem_to_reg  output  1  held select, 0 when out_valid=0
reg_write  output  1  held write enable, 0 when out_valid=0
wb_data  output  DATA_W  mem_to_reg ? mem_data : alu_out (combinational from held entry)

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - State EMPTY; all outputs 0 except in_ready, which is 1.
  - Skid entry cleared.
- Storage: main entry drives the outputs; skid entry holds one overflow entry.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Registered outputs: out_valid = (state != EMPTY); in_ready = (state != FULL2). Both derive from state only, with no combinational path from out_ready.
- States and transitions:
  - EMPTY: accept -> ONE, main <= input.
  - ONE, accept & drain: stay ONE, main <= input.
  - ONE, accept & !drain: -> FULL2, skid <= input.
  - ONE, !accept & drain: -> EMPTY.
  - ONE, otherwise: hold.
  - FULL2: in_ready=0, no accept. drain -> ONE, main <= skid. Otherwise hold.
- Ordering: strictly FIFO; an entry is never duplicated or dropped except by flush.
- Latency: accept in cycle N -> out_valid in cycle N+1 when EMPTY.
- Throughput: 1 entry/cycle while out_ready=1.
- Flush:
  - Highest priority: next state EMPTY; pc_src, mem_to_reg, reg_write cleared in both entries.
  - An entry accepted in the flush cycle is discarded.
  - Data fields hold their values and are don't-care.
- Drain to EMPTY clears the held control bits, so reg_write/pc_src are never asserted with out_valid=0.
- Widths: no arithmetic; wb_data is exactly DATA_W, with no extension.
- Reset asserted mid-operation: immediate return to reset values regardless of handshake.

Optional Feature:
- Macro MEMWB_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt [CNT_W].
  - Increments each cycle out_valid & !out_ready.
  - Saturates at all-ones.
  - Cleared by rst only, not by flush.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream with FULL2 held -> out_valid=0, reg_write=0, in_ready=1, wb_data=0 immediately, without waiting for a clock edge.
- Streaming with out_ready=1:
  - Stimulus: accept alu_out_in=0x11, 0x22, 0x33 on consecutive cycles.
  - Response: alu_out shows 0x11, 0x22, 0x33 one cycle later each; in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0, send entries A (rd=3) and B (rd=7).
  - Response: state FULL2, in_ready=0, rd_addr=3 held.
  - Release out_ready: A then B delivered in order, with no loss or duplication.
- Flush:
  - Stimulus: FULL2 with reg_write=1, pulse flush together with in_valid=1.
  - Response: next cycle out_valid=0, reg_write=0, pc_src=0; the incoming entry is dropped.
- wb_data mux:
  - mem_data_in=0xDEADBEEF, alu_out_in=0x1234, mem_to_reg_in=1 -> wb_data=0xDEADBEEF.
  - Same values with mem_to_reg_in=0 -> wb_data=0x1234.
- MEMWB_PERF_CNT_EN with CNT_W=4: hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15 (saturated); flush leaves it at 15.
